// File: rtl/regfile_px_if.sv
// Bus bundle for regfile_px: two write ports, two read ports, clear request and busy flag.
interface regfile_px_if #(
  parameter int WIDTH = 16,
  parameter int ABITS = 4
);
  logic             clr;
  logic             busy;
  logic             we_a;
  logic             we_b;
  logic [ABITS-1:0] wa_a;
  logic [ABITS-1:0] wa_b;
  logic [WIDTH-1:0] wd_a;
  logic [WIDTH-1:0] wd_b;
  logic [ABITS-1:0] ra1;
  logic [ABITS-1:0] ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;

  modport master (
    output clr, we_a, we_b, wa_a, wa_b, wd_a, wd_b, ra1, ra2,
    input  busy, rd1, rd2
  );

  modport slave (
    input  clr, we_a, we_b, wa_a, wa_b, wd_a, wd_b, ra1, ra2,
    output busy, rd1, rd2
  );
endinterface

// File: rtl/regfile_px.sv
// Two-write / two-read register file with an optional hardwired-zero r0, optional
// write-to-read forwarding and a one-register-per-cycle clear engine.
module regfile_px #(
  parameter int WIDTH   = 16,
  parameter int ABITS   = 4,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 0
) (
  input  logic         clk,
  input  logic         reset,
  regfile_px_if.slave  bus
);

  localparam int DEPTH = 2 ** ABITS;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t           state;
  logic [ABITS-1:0] ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_a;
  logic             wr_b;
  logic [ABITS-1:0] ra [2];
  logic [WIDTH-1:0] rd [2];

  always_comb begin
    wr_a = bus.we_a && !((ZERO_R0 != 0) && (bus.wa_a == '0));
    wr_b = bus.we_b && !((ZERO_R0 != 0) && (bus.wa_b == '0));
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values. The array is deliberately left out of the reset branch:
  // it must hold its contents while reset is low, and the sweep zeroes it afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Port B is written second so it wins on an address collision.
          if (wr_a) mem[bus.wa_a] <= bus.wd_a;
          if (wr_b) mem[bus.wa_b] <= bus.wd_b;
          if (bus.clr) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          mem[ptr] <= '0;
          if (bus.clr) begin
            ptr <= '0;
          end else begin
            ptr <= ptr + ABITS'(1);
            if (&ptr) state <= IDLE;
          end
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
        end
      endcase
    end
  end

  assign ra[0]    = bus.ra1;
  assign ra[1]    = bus.ra2;
  assign bus.rd1  = rd[0];
  assign bus.rd2  = rd[1];
  assign bus.busy = (state == CLEAR);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rd[i] = mem[ra[i]];
      if ((BYPASS != 0) && (state == IDLE)) begin
        if (bus.we_a && (bus.wa_a == ra[i])) rd[i] = bus.wd_a;
        if (bus.we_b && (bus.wa_b == ra[i])) rd[i] = bus.wd_b;
      end
      if ((ZERO_R0 != 0) && (ra[i] == '0)) rd[i] = '0;
      // Reset forces CLEAR asynchronously, so this also covers reads during reset.
      if (state == CLEAR) rd[i] = '0;
    end
  end

endmodule

// File: tb/tb_regfile_px.sv
// Directed bench for regfile_px: default, forwarding and 32x32 instances share stimulus;
// expectations go into a scoreboard queue and are popped when the outputs are sampled.
module tb_regfile_px;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        clr   = 1'b0;
  logic        we_a  = 1'b0;
  logic        we_b  = 1'b0;
  logic [3:0]  wa_a  = '0;
  logic [3:0]  wa_b  = '0;
  logic [3:0]  ra1   = '0;
  logic [3:0]  ra2   = '0;
  logic [15:0] wd_a  = '0;
  logic [15:0] wd_b  = '0;

  always #5 clk = ~clk;

  regfile_px_if #(.WIDTH(16), .ABITS(4)) if0 ();
  regfile_px_if #(.WIDTH(16), .ABITS(4)) if1 ();
  regfile_px_if #(.WIDTH(32), .ABITS(5)) if2 ();

  assign if0.clr  = clr;   assign if1.clr  = clr;
  assign if0.we_a = we_a;  assign if1.we_a = we_a;
  assign if0.we_b = we_b;  assign if1.we_b = we_b;
  assign if0.wa_a = wa_a;  assign if1.wa_a = wa_a;
  assign if0.wa_b = wa_b;  assign if1.wa_b = wa_b;
  assign if0.wd_a = wd_a;  assign if1.wd_a = wd_a;
  assign if0.wd_b = wd_b;  assign if1.wd_b = wd_b;
  assign if0.ra1  = ra1;   assign if1.ra1  = ra1;
  assign if0.ra2  = ra2;   assign if1.ra2  = ra2;

  assign if2.clr  = clr;
  assign if2.we_a = 1'b0;
  assign if2.we_b = 1'b0;
  assign if2.wa_a = '0;
  assign if2.wa_b = '0;
  assign if2.wd_a = '0;
  assign if2.wd_b = '0;
  assign if2.ra1  = '0;
  assign if2.ra2  = '0;

  regfile_px #(.WIDTH(16), .ABITS(4), .ZERO_R0(1), .BYPASS(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  regfile_px #(.WIDTH(16), .ABITS(4), .ZERO_R0(1), .BYPASS(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  regfile_px #(.WIDTH(32), .ABITS(5), .ZERO_R0(1), .BYPASS(0)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: got %h want nothing", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s: got %h want %h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Counts busy cycles on dut0 and dut2 from the current negedge until both are idle;
  // optionally re-requests a clear at busy cycle clr_at and tries a write at wr_at.
  task automatic run_busy(input int clr_at, input int wr_at, output int n0, output int n2);
    n0 = 0;
    n2 = 0;
    for (int c = 1; c <= 200 && (if0.busy || if2.busy); c++) begin
      if (if0.busy) n0++;
      if (if2.busy) n2++;
      clr  = (c == clr_at);
      we_a = (c == wr_at);
      wa_a = 4'd2;
      wd_a = 16'h7777;
      if (c == wr_at) begin
        ra1 = 4'd2;
        ra2 = 4'd9;
        #1;
        expect_val("fwd_blocked_in_clear", 32'h0);
        check(32'(if1.rd1));
        expect_val("rd_zero_in_clear", 32'h0);
        check(32'(if0.rd2));
      end
      @(negedge clk);
    end
    clr  = 1'b0;
    we_a = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, n2;

    // Reset held low: busy forced, reads zero.
    ra1 = 4'd5;
    repeat (3) @(negedge clk);
    expect_val("busy_in_reset_16", 32'h1);
    check(32'(if0.busy));
    expect_val("busy_in_reset_32", 32'h1);
    check(32'(if2.busy));
    expect_val("rd_in_reset", 32'h0);
    check(32'(if0.rd1));

    // Release: 16 / 32 busy cycles, then everything reads zero.
    reset = 1'b1;
    run_busy(0, 0, n0, n2);
    expect_val("reset_sweep_16", 32'd16);
    check(32'(n0));
    expect_val("reset_sweep_32", 32'd32);
    check(32'(n2));
    ra1 = 4'd5;
    #1;
    expect_val("reg5_after_reset", 32'h0);
    check(32'(if0.rd1));
    expect_val("reg5_after_reset_fwd", 32'h0);
    check(32'(if1.rd1));

    // Old value then new value on the plain instance, same-cycle value with forwarding.
    we_a = 1'b1; wa_a = 4'd3; wd_a = 16'h1111;
    @(negedge clk);
    wd_a = 16'h1234; ra1 = 4'd3;
    #1;
    expect_val("nofwd_old_value", 32'h1111);
    check(32'(if0.rd1));
    expect_val("fwd_same_cycle", 32'h1234);
    check(32'(if1.rd1));
    @(negedge clk);
    we_a = 1'b0;
    #1;
    expect_val("nofwd_after_edge", 32'h1234);
    check(32'(if0.rd1));
    expect_val("fwd_after_edge", 32'h1234);
    check(32'(if1.rd1));

    // Same-address collision: B wins, also in forwarding.
    we_a = 1'b1; wa_a = 4'd7; wd_a = 16'hAAAA;
    we_b = 1'b1; wa_b = 4'd7; wd_b = 16'h5555;
    ra1 = 4'd7;
    #1;
    expect_val("fwd_b_over_a", 32'h5555);
    check(32'(if1.rd1));
    expect_val("nofwd_collision_old", 32'h0);
    check(32'(if0.rd1));
    @(negedge clk);
    we_a = 1'b0; we_b = 1'b0;
    #1;
    expect_val("collision_b_wins", 32'h5555);
    check(32'(if0.rd1));
    expect_val("collision_b_wins_fwd", 32'h5555);
    check(32'(if1.rd1));

    // Register 0 stays zero, forwarding never applies to it.
    we_a = 1'b1; wa_a = 4'd0; wd_a = 16'hFFFF; ra2 = 4'd0;
    #1;
    expect_val("r0_no_fwd", 32'h0);
    check(32'(if1.rd2));
    @(negedge clk);
    we_a = 1'b0;
    #1;
    expect_val("r0_after_write", 32'h0);
    check(32'(if0.rd2));
    expect_val("r0_after_write_fwd", 32'h0);
    check(32'(if1.rd2));
    ra2 = 4'd3;
    #1;
    expect_val("rd2_reg3", 32'h1234);
    check(32'(if0.rd2));

    // Clear request: write during busy is dropped, contents zeroed.
    @(negedge clk);
    we_a = 1'b1; wa_a = 4'd9; wd_a = 16'hBEEF;
    @(negedge clk);
    we_a = 1'b0; ra1 = 4'd9;
    #1;
    expect_val("reg9_filled", 32'hBEEF);
    check(32'(if0.rd1));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    run_busy(0, 3, n0, n2);
    expect_val("clr_busy_16", 32'd16);
    check(32'(n0));
    expect_val("clr_busy_32", 32'd32);
    check(32'(n2));
    ra1 = 4'd9; ra2 = 4'd2;
    #1;
    expect_val("reg9_cleared", 32'h0);
    check(32'(if0.rd1));
    expect_val("reg2_write_dropped", 32'h0);
    check(32'(if0.rd2));
    expect_val("reg2_write_dropped_fwd", 32'h0);
    check(32'(if1.rd2));
    expect_val("idle_after_clear", 32'h0);
    check(32'(if0.busy));

    // Restart the sweep at busy cycle 8.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    run_busy(8, 0, n0, n2);
    expect_val("restart_busy_24", 32'd24);
    check(32'(n0));
    expect_val("restart_busy_40", 32'd40);
    check(32'(n2));

    // Reset mid-clear at ptr = 5: busy stays high, full sweep after release.
    we_a = 1'b1; wa_a = 4'd11; wd_a = 16'h4242;
    @(negedge clk);
    we_a = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    ra1 = 4'd11;
    #1;
    expect_val("busy_mid_reset_16", 32'h1);
    check(32'(if0.busy));
    expect_val("busy_mid_reset_32", 32'h1);
    check(32'(if2.busy));
    expect_val("rd_mid_reset", 32'h0);
    check(32'(if0.rd1));
    @(negedge clk);
    @(negedge clk);
    expect_val("busy_held_in_reset", 32'h1);
    check(32'(if0.busy));
    reset = 1'b1;
    run_busy(0, 0, n0, n2);
    expect_val("reset_restart_16", 32'd16);
    check(32'(n0));
    expect_val("reset_restart_32", 32'd32);
    check(32'(n2));
    #1;
    expect_val("reg11_after_reset_clear", 32'h0);
    check(32'(if0.rd1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_px.md
REGFILE_PX -- requirements
Module: regfile_px

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 Parameter ABITS, default 4, address width; register count DEPTH = 2**ABITS.
REQ-003 Parameter ZERO_R0, default 1, register 0 is hardwired to zero when 1.
REQ-004 Parameter BYPASS, default 0, same-cycle write-to-read forwarding when 1.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 clr  input  1  synchronous request to zero the whole array.
REQ-008 busy  output  1  high while the clear engine runs.
REQ-009 we_a, we_b  input  1 each  write enables, ports A and B.
REQ-010 wa_a, wa_b  input  ABITS each  write addresses.
REQ-011 wd_a, wd_b  input  WIDTH each  write data.
REQ-012 ra1, ra2  input  ABITS each  read addresses.
REQ-013 rd1, rd2  output  WIDTH each  combinational read data.

Function
REQ-014 The block SHALL hold DEPTH registers of WIDTH bits and implement a two-state FSM, IDLE and CLEAR, plus an ABITS-bit clear pointer ptr.
REQ-015 In IDLE, each enabled write port SHALL store its data at its address on the rising edge.
REQ-016 If we_a and we_b are both high with wa_a == wa_b, port B SHALL win and port A's write is discarded.
REQ-017 With ZERO_R0=1, writes to address 0 SHALL be ignored and reads of address 0 SHALL return 0.
REQ-018 With BYPASS=0, rdN SHALL return the stored value (new data visible the cycle after the write edge).
REQ-019 With BYPASS=1 in IDLE, if raN matches an enabled write address, rdN SHALL return that write data combinationally, B over A; never for address 0 when ZERO_R0=1.
REQ-020 In CLEAR, each edge SHALL write 0 to register ptr and increment ptr; the edge at ptr == DEPTH-1 SHALL return to IDLE, ptr wrapping to 0.
REQ-021 A clear SHALL take exactly DEPTH cycles; busy SHALL equal (state == CLEAR).
REQ-022 In CLEAR, we_a/we_b SHALL be ignored (writes dropped, not queued) and rd1/rd2 SHALL read 0.
REQ-023 clr high in IDLE SHALL enter CLEAR with ptr = 0 on the next edge; writes presented that same cycle SHALL still be performed, then overwritten by the clear.
REQ-024 clr high in CLEAR SHALL restart the sweep (ptr = 0 on next edge), extending busy.
REQ-025 Register contents SHALL never change except through REQ-015/016/020.

Reset
REQ-026 reset low SHALL immediately force state = CLEAR, ptr = 0, busy = 1, independent of clk.
REQ-027 While reset is low, array contents SHALL hold and rd1/rd2 SHALL read 0.
REQ-028 After reset rises, the first edge SHALL clear register 0; IDLE SHALL be reached after DEPTH edges, with every register 0.
REQ-029 reset asserted mid-clear SHALL restart the sweep from ptr = 0.

Verification
REQ-030 Defaults: release reset, count edges -> busy high exactly 16 cycles, then ra1=5 -> rd1 = 0x0000.
REQ-031 IDLE, we_a=1 wa_a=3 wd_a=0x1234, ra1=3, BYPASS=0 -> rd1 old value in same cycle, 0x1234 after edge; BYPASS=1 -> 0x1234 same cycle.
REQ-032 we_a=1 wa_a=7 wd_a=0xAAAA, we_b=1 wa_b=7 wd_b=0x5555 -> reg 7 = 0x5555; we_a wa_a=0 wd_a=0xFFFF -> ra2=0 reads 0x0000.
REQ-033 Fill reg 9 = 0xBEEF, pulse clr -> busy 16 cycles, write to reg 2 during busy dropped, reg 9 and reg 2 read 0 afterwards.
REQ-034 Pulse clr at cycle 8 of an active clear -> busy total 8+16 = 24 cycles.
REQ-035 Assert reset low mid-clear at ptr=5 -> busy stays high, sweep restarts at 0 after release, 16 cycles to IDLE; repeat with WIDTH=32, ABITS=5 -> 32 cycles.
